// File: rtl/count_mode_sequencer.sv
// Command-driven mode sequencer for the universal counter: drives S1/S0/P from
// run/stop/load commands and returns the counter to HOLD after a programmed wrap count.
module count_mode_sequencer #(
    parameter int length = 10,
    parameter int WRAPW  = 8
) (
    input  logic              CLOCK,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [length-1:0] cmd_data,
    input  logic [WRAPW-1:0]  cmd_wraps,
    input  logic              TerminalCount,
    output logic              S1,
    output logic              S0,
    output logic [length-1:0] P,
    output logic              busy,
    output logic              done,
    output logic [WRAPW-1:0]  wrap_count
);

    // State encoding doubles as the counter mode select {S1,S0}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_LOAD = 2'b11
    } state_t;

    localparam logic [1:0] OP_STOP     = 2'd0;
    localparam logic [1:0] OP_RUN_UP   = 2'd1;
    localparam logic [1:0] OP_RUN_DOWN = 2'd2;
    localparam logic [1:0] OP_LOAD     = 2'd3;

    state_t             r_state;
    logic [length-1:0]  r_p;
    logic [WRAPW-1:0]   r_wrap_count;
    logic [WRAPW-1:0]   r_target;
    logic               r_done;

    state_t             w_state_next;
    logic [length-1:0]  w_p_next;
    logic [WRAPW-1:0]   w_wrap_count_next;
    logic [WRAPW-1:0]   w_target_next;
    logic               w_done_next;
    logic               w_accept;
    logic [WRAPW-1:0]   w_wrap_inc;

    assign cmd_ready  = !Reset && (r_state != ST_LOAD);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_wrap_inc = r_wrap_count + 1'b1;

    always_comb begin
        w_state_next      = r_state;
        w_p_next          = r_p;
        w_wrap_count_next = r_wrap_count;
        w_target_next     = r_target;
        w_done_next       = 1'b0;

        if (r_state == ST_LOAD) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
        end else if (w_accept) begin
            // A command always wins over a coincident wrap: no tally, no done.
            case (cmd_op)
                OP_STOP: begin
                    w_state_next = ST_IDLE;
                end
                OP_RUN_UP: begin
                    w_state_next      = ST_UP;
                    w_target_next     = cmd_wraps;
                    w_wrap_count_next = '0;
                end
                OP_RUN_DOWN: begin
                    w_state_next      = ST_DOWN;
                    w_target_next     = cmd_wraps;
                    w_wrap_count_next = '0;
                end
                default: begin
                    w_state_next = ST_LOAD;
                    w_p_next     = cmd_data;
                end
            endcase
        end else if (r_state != ST_IDLE && TerminalCount) begin
            if (r_target == '0) begin
                if (r_wrap_count != '1) begin
                    w_wrap_count_next = w_wrap_inc;
                end
            end else begin
                w_wrap_count_next = w_wrap_inc;
                // The counter still sees the run mode at this edge, so the final wrap completes.
                if (w_wrap_inc == r_target) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_p          <= '0;
            r_wrap_count <= '0;
            r_target     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_p          <= w_p_next;
            r_wrap_count <= w_wrap_count_next;
            r_target     <= w_target_next;
            r_done       <= w_done_next;
        end
    end

    assign {S1, S0}   = r_state;
    assign P          = r_p;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_count_mode_sequencer.sv
// Directed bench for count_mode_sequencer driving a behavioural 0..9 up/down/load counter;
// expected outputs are queued per cycle and compared after each rising edge.
module tb_count_mode_sequencer;

    localparam int LEN   = 10;
    localparam int WW    = 8;
    localparam logic [LEN-1:0] BEGIN_CNT = 10'd0;
    localparam logic [LEN-1:0] END_CNT   = 10'd9;

    logic            CLOCK = 1'b0;
    logic            Reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [LEN-1:0]  cmd_data;
    logic [WW-1:0]   cmd_wraps;
    logic            TerminalCount;
    logic            S1, S0;
    logic [LEN-1:0]  P;
    logic            busy, done;
    logic [WW-1:0]   wrap_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        int    s;
        int    p;
        int    busy;
        int    done;
        int    ready;
        int    wc;
    } exp_t;

    exp_t sb[$];

    count_mode_sequencer #(.length(LEN), .WRAPW(WW)) dut (
        .CLOCK        (CLOCK),
        .Reset        (Reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_wraps    (cmd_wraps),
        .TerminalCount(TerminalCount),
        .S1           (S1),
        .S0           (S0),
        .P            (P),
        .busy         (busy),
        .done         (done),
        .wrap_count   (wrap_count)
    );

    always #5 CLOCK = ~CLOCK;

    // Behavioural universal counter with Begin=0, End=9.
    logic [LEN-1:0] cnt;
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            cnt <= '0;
        end else begin
            case ({S1, S0})
                2'b01:   cnt <= (cnt == END_CNT) ? BEGIN_CNT : cnt + 1'b1;
                2'b10:   cnt <= (cnt == BEGIN_CNT) ? END_CNT : cnt - 1'b1;
                2'b11:   cnt <= P;
                default: cnt <= cnt;
            endcase
        end
    end
    assign TerminalCount = (({S1, S0} == 2'b01) && (cnt == END_CNT)) ||
                           (({S1, S0} == 2'b10) && (cnt == BEGIN_CNT));

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLOCK);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_empty: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".S"},     int'({S1, S0}),   e.s);
            chk({e.tag, ".P"},     int'(P),          e.p);
            chk({e.tag, ".busy"},  int'(busy),       e.busy);
            chk({e.tag, ".done"},  int'(done),       e.done);
            chk({e.tag, ".ready"}, int'(cmd_ready),  e.ready);
            chk({e.tag, ".wc"},    int'(wrap_count), e.wc);
            $display("[TB] %s S=%0d P=0x%0h busy=%0d done=%0d ready=%0d wc=%0d cnt=%0d",
                     e.tag, {S1, S0}, P, busy, done, cmd_ready, wrap_count, cnt);
        end
    endtask

    task automatic cyc(input string tag, input int s, input int p, input int b,
                       input int d, input int r, input int wc);
        exp_t e;
        e.tag = tag; e.s = s; e.p = p; e.busy = b; e.done = d; e.ready = r; e.wc = wc;
        sb.push_back(e);
        step();
    endtask

    task automatic send(input logic [1:0] op, input logic [LEN-1:0] data, input logic [WW-1:0] wraps);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_wraps = wraps;
    endtask

    initial begin
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        cmd_wraps = '0;

        // Reset held two cycles, then idle.
        cyc("rst0", 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        cyc("idle", 0, 0, 0, 0, 1, 0);

        send(2'd0, '0, '0);
        cyc("stop_idle", 0, 0, 0, 0, 1, 0);
        cmd_valid = 1'b0;

        // RUN_UP for two wraps: wraps land on edges 10 and 20 after accept.
        send(2'd1, '0, 8'd2);
        cyc("up2_acc", 1, 0, 1, 0, 1, 0);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 19; i++) cyc("up2_run", 1, 0, 1, 0, 1, (i >= 10) ? 1 : 0);
        cyc("up2_done", 0, 0, 0, 1, 1, 2);
        cyc("up2_after", 0, 0, 0, 0, 1, 2);
        chk("up2_cnt_hold", int'(cnt), 0);

        // LOAD 0x1A5.
        send(2'd3, 10'h1A5, '0);
        cyc("ld_acc", 3, 'h1A5, 1, 0, 0, 2);
        cmd_valid = 1'b0;
        cyc("ld_done", 0, 'h1A5, 0, 1, 1, 2);
        chk("ld_cnt", int'(cnt), 'h1A5);
        cyc("ld_after", 0, 'h1A5, 0, 0, 1, 2);

        send(2'd3, 10'h000, '0);
        cyc("ld0_acc", 3, 0, 1, 0, 0, 2);
        cmd_valid = 1'b0;
        cyc("ld0_done", 0, 0, 0, 1, 1, 2);

        // RUN_DOWN unbounded from count 0: wraps on edges 1, 11, 21, ... after accept.
        send(2'd2, '0, 8'd0);
        cyc("dn_acc", 2, 0, 1, 0, 1, 0);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 295; i++) cyc("dn_run", 2, 0, 1, 0, 1, (i - 1) / 10 + 1);
        send(2'd0, '0, '0);
        cyc("dn_stop", 0, 0, 0, 0, 1, 30);
        cmd_valid = 1'b0;
        cyc("dn_after", 0, 0, 0, 0, 1, 30);

        // STOP coincident with the final wrap of a one-wrap run: abort, no done.
        send(2'd3, 10'h000, '0);
        cyc("ld0b_acc", 3, 0, 1, 0, 0, 30);
        cmd_valid = 1'b0;
        cyc("ld0b_done", 0, 0, 0, 1, 1, 30);
        send(2'd1, '0, 8'd1);
        cyc("up1_acc", 1, 0, 1, 0, 1, 0);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 9; i++) cyc("up1_run", 1, 0, 1, 0, 1, 0);
        chk("up1_tc_high", int'(TerminalCount), 1);
        send(2'd0, '0, '0);
        cyc("up1_stop", 0, 0, 0, 0, 1, 0);
        cmd_valid = 1'b0;
        cyc("up1_after", 0, 0, 0, 0, 1, 0);

        // Reset in the middle of a run with wrap_count=3.
        send(2'd3, 10'd9, '0);
        cyc("ld9_acc", 3, 9, 1, 0, 0, 0);
        cmd_valid = 1'b0;
        cyc("ld9_done", 0, 9, 0, 1, 1, 0);
        send(2'd1, '0, 8'd5);
        cyc("up5_acc", 1, 9, 1, 0, 1, 0);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 25; i++) cyc("up5_run", 1, 9, 1, 0, 1, (i + 9) / 10);
        Reset = 1'b1;
        cyc("rst_mid", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        cyc("rst_mid_after", 0, 0, 0, 0, 1, 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
